// File: rtl/touch_pkg.sv
// Shared state encoding and constants for the touch-panel SPI master.
// The GAP state exists only when TOUCH_SPI_AVG_EN is defined.
package touch_pkg;

    localparam int unsigned XFER_CLKS = 24;
    localparam int unsigned CMD_BITS  = 8;

    localparam logic [7:0] CMD_X = 8'hD0;
    localparam logic [7:0] CMD_Y = 8'h90;

`ifdef TOUCH_SPI_AVG_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_GAP
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_e;
`endif

endpackage

// File: rtl/touch_clkdiv.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled,
// counting restarts from 0 whenever the enable drops.
module touch_clkdiv #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/touch_spi_master.sv
// XPT2046-style touch ADC SPI master: one 24-clock conversion per start.
// With TOUCH_SPI_AVG_EN defined, four conversions are averaged per start.
module touch_spi_master
    import touch_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [11:0] data,
    input  logic        touch_dout,
    output logic        touch_dclk,
    output logic        touch_cs,
    output logic        touch_din
);

    localparam logic [5:0] HP_LAST = 6'(2 * XFER_CLKS - 1);
    localparam logic [5:0] HP_CMD  = 6'(2 * CMD_BITS);
    localparam logic [5:0] HP_MSB  = 6'(2 * (CMD_BITS + 2) - 2);
    localparam logic [5:0] HP_LSB  = 6'(2 * (CMD_BITS + 13) - 2);

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [5:0]  hp_q, hp_d;
    logic [11:0] rx_q, rx_d;
    logic [11:0] data_q, data_d;
    logic        done_q, done_d;
    logic        tick;

`ifdef TOUCH_SPI_AVG_EN
    logic [1:0]  conv_q, conv_d;
    logic [13:0] acc_q, acc_d;
    logic [13:0] sum;
`endif

    touch_clkdiv #(
        .CLK_DIV(CLK_DIV)
    ) u_clkdiv (
        .clk_i (HCLK),
        .rst_ni(HRESETn),
        .en_i  (busy),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        hp_d    = hp_q;
        rx_d    = rx_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef TOUCH_SPI_AVG_EN
        conv_d  = conv_q;
        acc_d   = acc_q;
        sum     = acc_q + {2'b00, rx_q};
`endif
        if (abort) begin
            state_d = ST_IDLE;
            hp_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_SETUP;
                        cmd_d   = cmd;
                        hp_d    = '0;
`ifdef TOUCH_SPI_AVG_EN
                        conv_d  = '0;
                        acc_d   = '0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state_d = ST_XFER;
                        hp_d    = '0;
                    end
                end
                ST_XFER: begin
                    if (tick) begin
                        // Only rx[14:3] ever reaches data, so only clocks 10-21 are stored.
                        if (!hp_q[0] && hp_q >= HP_MSB && hp_q <= HP_LSB) begin
                            rx_d = {rx_q[10:0], touch_dout};
                        end
                        if (hp_q == HP_LAST) begin
                            state_d = ST_HOLD;
                            hp_d    = '0;
                        end else begin
                            hp_d = hp_q + 6'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
`ifdef TOUCH_SPI_AVG_EN
                        if (conv_q == 2'd3) begin
                            state_d = ST_IDLE;
                            data_d  = sum[13:2];
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            acc_d   = sum;
                            conv_d  = conv_q + 2'd1;
                        end
`else
                        state_d = ST_IDLE;
                        data_d  = rx_q;
                        done_d  = 1'b1;
`endif
                    end
                end
`ifdef TOUCH_SPI_AVG_EN
                ST_GAP: begin
                    if (tick) begin
                        state_d = ST_SETUP;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            hp_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef TOUCH_SPI_AVG_EN
            conv_q  <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            hp_q    <= hp_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            done_q  <= done_d;
`ifdef TOUCH_SPI_AVG_EN
            conv_q  <= conv_d;
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        touch_din = 1'b0;
        if (state_q == ST_SETUP) begin
            touch_din = cmd_q[7];
        end else if (state_q == ST_XFER && hp_q < HP_CMD) begin
            touch_din = cmd_q[~hp_q[3:1]];
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign data       = data_q;
    assign touch_dclk = (state_q == ST_XFER) && hp_q[0];
`ifdef TOUCH_SPI_AVG_EN
    assign touch_cs   = (state_q == ST_IDLE) || (state_q == ST_GAP);
`else
    assign touch_cs   = (state_q == ST_IDLE);
`endif

endmodule

// File: tb/tb_touch_spi_master.sv
// Directed bench for touch_spi_master at CLK_DIV=4 with a behavioural XPT2046 model.
module tb_touch_spi_master;
    import touch_pkg::*;

    localparam int unsigned DIV = 4;
`ifdef TOUCH_SPI_AVG_EN
    localparam int unsigned NCONV = 4;
    localparam int unsigned LAT   = 203 * DIV + 1;
`else
    localparam int unsigned NCONV = 1;
    localparam int unsigned LAT   = 50 * DIV + 1;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [7:0]  cmd;
    logic        abort;
    logic        busy;
    logic        done;
    logic [11:0] data;
    logic        touch_dout;
    logic        touch_dclk;
    logic        touch_cs;
    logic        touch_din;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    logic [11:0] adc_vals [4];
    int unsigned conv_base = 0;
    int unsigned cs_falls  = 0;
    int unsigned conv_idx  = 0;
    int unsigned rise_n    = 0;
    int unsigned total_rises = 0;
    int unsigned din_bad   = 0;
    logic [7:0]  din_byte  = '0;
    logic [7:0]  din_cap   = '0;

    touch_spi_master #(
        .CLK_DIV(DIV)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start     (start),
        .cmd       (cmd),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .data      (data),
        .touch_dout(touch_dout),
        .touch_dclk(touch_dclk),
        .touch_cs  (touch_cs),
        .touch_din (touch_din)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc++;

    always @(negedge touch_cs or posedge touch_dclk) begin
        if (touch_dclk) begin
            rise_n++;
            total_rises++;
            if (rise_n <= 8) begin
                din_byte = {din_byte[6:0], touch_din};
                if (rise_n == 8) din_cap = din_byte;
            end else if (touch_din !== 1'b0) begin
                din_bad++;
            end
        end else begin
            rise_n   = 0;
            conv_idx = (cs_falls - conv_base) % 4;
            cs_falls++;
        end
    end

    // ADC drives the bit for the next clock after each falling DCLK edge.
    always @(negedge touch_dclk) begin
        int unsigned m;
        logic [11:0] v;
        m = rise_n + 1;
        v = adc_vals[conv_idx];
        if (m >= 10 && m <= 21) touch_dout = v[21 - m];
        else touch_dout = 1'b0;
    end

    task automatic set_adc(input logic [11:0] v0, input logic [11:0] v1,
                           input logic [11:0] v2, input logic [11:0] v3);
        adc_vals[0] = v0;
        adc_vals[1] = v1;
        adc_vals[2] = v2;
        adc_vals[3] = v3;
        conv_base   = cs_falls;
    endtask

    task automatic kick(input logic [7:0] c, output int unsigned st);
        @(posedge HCLK);
        #1;
        start = 1'b1;
        cmd   = c;
        st    = cyc;
        @(posedge HCLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned maxc, output int unsigned at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int unsigned i = 0; i < maxc; i++) begin
            @(negedge HCLK);
            if (done === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        start   = 1'b0;
        cmd     = '0;
        abort   = 1'b0;
        repeat (3) @(negedge HCLK);
        total++; if (touch_cs !== 1'b1) begin bad++; $display("FAIL reset_cs got=%b exp=1", touch_cs); end
        total++; if (touch_dclk !== 1'b0) begin bad++; $display("FAIL reset_dclk got=%b exp=0", touch_dclk); end
        total++; if (touch_din !== 1'b0) begin bad++; $display("FAIL reset_din got=%b exp=0", touch_din); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (data !== 12'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", data); end
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
    endtask

    task automatic test_basic;
        int unsigned st, at, r0, b0;
        bit ok;
        set_adc(12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C);
        r0 = total_rises;
        b0 = din_bad;
        kick(CMD_X, st);
        wait_done(LAT + 20, at, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout got=none exp=done"); end
        total++; if (at - st !== LAT) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", at - st, LAT); end
        total++; if (data !== 12'hA5C) begin bad++; $display("FAIL basic_data got=%h exp=a5c", data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        total++; if (touch_cs !== 1'b1) begin bad++; $display("FAIL basic_cs_at_done got=%b exp=1", touch_cs); end
        total++; if (din_cap !== 8'hD0) begin bad++; $display("FAIL basic_din_cmd got=%h exp=d0", din_cap); end
        total++; if (din_bad !== b0) begin bad++; $display("FAIL basic_din_zero got=%0d exp=%0d", din_bad, b0); end
        total++; if (total_rises - r0 !== 24 * NCONV) begin
            bad++; $display("FAIL basic_rises got=%0d exp=%0d", total_rises - r0, 24 * NCONV);
        end
        @(negedge HCLK);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_ignore;
        int unsigned st, rel, ndone, gaps;
        set_adc(12'h123, 12'h123, 12'h123, 12'h123);
        ndone = 0;
        gaps  = 0;
        kick(CMD_Y, st);
        for (int unsigned i = 0; i < 2 * LAT; i++) begin
            @(negedge HCLK);
            rel = cyc - st;
            if (rel == 10) begin start = 1'b1; cmd = CMD_X; end
            if (rel == 11) start = 1'b0;
            if (done === 1'b1) ndone++;
            if (rel >= 1 && rel < LAT && busy !== 1'b1) gaps++;
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        total++; if (gaps !== 0) begin bad++; $display("FAIL ignore_busy_gaps got=%0d exp=0", gaps); end
        total++; if (din_cap !== 8'h90) begin bad++; $display("FAIL ignore_cmd got=%h exp=90", din_cap); end
        total++; if (data !== 12'h123) begin bad++; $display("FAIL ignore_data got=%h exp=123", data); end
    endtask

    task automatic test_abort;
        int unsigned st, at, ndone;
        bit ok, hit;
        set_adc(12'h777, 12'h777, 12'h777, 12'h777);
        kick(CMD_X, st);
        hit = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            @(negedge HCLK);
            if (rise_n >= 12) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("FAIL abort_rise12_timeout got=%0d exp=12", rise_n); end
        abort = 1'b1;
        @(negedge HCLK);
        abort = 1'b0;
        total++; if (touch_cs !== 1'b1) begin bad++; $display("FAIL abort_cs got=%b exp=1", touch_cs); end
        total++; if (touch_dclk !== 1'b0) begin bad++; $display("FAIL abort_dclk got=%b exp=0", touch_dclk); end
        total++; if (touch_din !== 1'b0) begin bad++; $display("FAIL abort_din got=%b exp=0", touch_din); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        ndone = 0;
        for (int unsigned i = 0; i < LAT + 10; i++) begin
            @(negedge HCLK);
            if (done === 1'b1) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
        total++; if (data !== 12'h123) begin bad++; $display("FAIL abort_data_kept got=%h exp=123", data); end
        set_adc(12'h777, 12'h777, 12'h777, 12'h777);
        kick(CMD_Y, st);
        wait_done(LAT + 20, at, ok);
        total++; if (!ok || at - st !== LAT) begin
            bad++; $display("FAIL abort_restart_latency got=%0d exp=%0d", at - st, LAT);
        end
        total++; if (data !== 12'h777) begin bad++; $display("FAIL abort_restart_data got=%h exp=777", data); end
    endtask

    task automatic test_reset_mid;
        int unsigned st, ndone, nbusy;
        bit hit;
        set_adc(12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5);
        kick(CMD_X, st);
        hit = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            @(negedge HCLK);
            if (rise_n >= 15) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("FAIL rstmid_xfer_timeout got=%0d exp=15", rise_n); end
        HRESETn = 1'b0;
        #1;
        total++; if (touch_cs !== 1'b1) begin bad++; $display("FAIL rstmid_cs got=%b exp=1", touch_cs); end
        total++; if (touch_dclk !== 1'b0) begin bad++; $display("FAIL rstmid_dclk got=%b exp=0", touch_dclk); end
        total++; if (touch_din !== 1'b0) begin bad++; $display("FAIL rstmid_din got=%b exp=0", touch_din); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (data !== 12'h000) begin bad++; $display("FAIL rstmid_data got=%h exp=000", data); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int unsigned i = 0; i < LAT + 20; i++) begin
            @(negedge HCLK);
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) nbusy++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
        total++; if (nbusy !== 0) begin bad++; $display("FAIL rstmid_idle got=%0d exp=0", nbusy); end
    endtask

    task automatic test_back_to_back;
        int unsigned st, d1, d2, cshi;
        bit ok, got2;
        set_adc(12'h3C5, 12'h3C5, 12'h3C5, 12'h3C5);
        kick(CMD_X, st);
        wait_done(LAT + 20, d1, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout got=none exp=done"); end
        start = 1'b1;
        cmd   = CMD_Y;
        cshi  = (touch_cs === 1'b1 && busy === 1'b0) ? 1 : 0;
        got2  = 1'b0;
        d2    = 0;
        for (int unsigned i = 0; i < LAT + 20; i++) begin
            @(negedge HCLK);
            start = 1'b0;
            if (done === 1'b1) begin got2 = 1'b1; d2 = cyc; break; end
            if (touch_cs === 1'b1 && busy === 1'b0) cshi++;
        end
        total++; if (!got2 || d2 - d1 !== LAT) begin
            bad++; $display("FAIL b2b_second_latency got=%0d exp=%0d", d2 - d1, LAT);
        end
        total++; if (cshi !== 1) begin bad++; $display("FAIL b2b_cs_high_cycles got=%0d exp=1", cshi); end
        total++; if (data !== 12'h3C5) begin bad++; $display("FAIL b2b_data got=%h exp=3c5", data); end
        total++; if (din_cap !== 8'h90) begin bad++; $display("FAIL b2b_cmd got=%h exp=90", din_cap); end
    endtask

`ifdef TOUCH_SPI_AVG_EN
    task automatic test_avg;
        int unsigned st, at, f0;
        bit ok;
        set_adc(12'd100, 12'd101, 12'd102, 12'd104);
        f0 = cs_falls;
        kick(CMD_X, st);
        wait_done(LAT + 20, at, ok);
        total++; if (!ok || at - st !== 813) begin bad++; $display("FAIL avg_latency got=%0d exp=813", at - st); end
        total++; if (data !== 12'd101) begin bad++; $display("FAIL avg_data got=%0d exp=101", data); end
        total++; if (cs_falls - f0 !== 4) begin bad++; $display("FAIL avg_cs_windows got=%0d exp=4", cs_falls - f0); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_ignore();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef TOUCH_SPI_AVG_EN
        test_avg();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
